ip_bus_dma: RTL and testbench

IP_BUS_DMA -- requirements
Module: ip_bus_dma

---
 rtl/ip_bus_dma_pkg.sv | 15 +
 rtl/ip_bus_dma_fifo.sv | 54 +++++
 rtl/ip_bus_dma.sv | 249 ++++++++++++++++++++++++
 tb/tb_ip_bus_dma.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_bus_dma_pkg.sv
// Shared types and default sizing for the ip_bus_dma byte-copy engine.
package ip_bus_dma_pkg;

   localparam int DEFAULT_BUF_DEPTH = 4;
   localparam int DEFAULT_ADDR_W    = 14;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      DRAIN = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } dma_state_e;

endpackage

// File: rtl/ip_bus_dma_fifo.sv
// Show-ahead byte FIFO that stages read data between the read and write phases.
module ip_bus_dma_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [7:0]               wdata,
   input  logic                     pop,
   output logic [7:0]               rdata,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

   logic [7:0]       mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   count_r;
   logic             do_push_s;
   logic             do_pop_s;

   // Qualify requests against occupancy; a pop frees room for a same-cycle push
   always_comb begin
      do_pop_s  = pop && (count_r != '0);
      do_push_s = push && ((count_r != FULL_LVL) || do_pop_s);
   end

   // Storage, pointers and occupancy
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 8'h00;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         count_r <= count_r + (PTR_W + 1)'(do_push_s) - (PTR_W + 1)'(do_pop_s);
      end
   end

   assign rdata = mem_r[rd_ptr_r];
   assign count = count_r;

endmodule

// File: rtl/ip_bus_dma.sv
// Chunked memory-to-memory byte copy engine on the RAM bus (registered bus outputs).
// Optional IP_BUS_DMA_FILL_EN adds a pattern-fill command mode.
module ip_bus_dma
   import ip_bus_dma_pkg::*;
#(
   parameter int BUF_DEPTH = DEFAULT_BUF_DEPTH,
   parameter int ADDR_W    = DEFAULT_ADDR_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_src,
   input  logic [ADDR_W-1:0] cmd_dst,
   input  logic [ADDR_W-1:0] cmd_len,
`ifdef IP_BUS_DMA_FILL_EN
   input  logic              cmd_fill,
   input  logic [7:0]        cmd_pattern,
`endif
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] bus_address,
   output logic              bus_valid,
   input  logic              bus_ready,
   output logic              bus_write,
   output logic [7:0]        bus_wdata,
   input  logic [7:0]        bus_rdata,
   input  logic              bus_rdata_en
);

   localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

   dma_state_e        state_r, state_s;
   logic [ADDR_W-1:0] src_r, src_s, dst_r, dst_s, rem_r, rem_s;
   logic [CNT_W-1:0]  chunk_r, chunk_s, rd_cnt_r, rd_cnt_s, rx_cnt_r, rx_cnt_s, wr_cnt_r, wr_cnt_s;
   logic              fill_r, fill_s;
   logic [7:0]        pattern_r, pattern_s;
   logic              bus_valid_r, valid_s, bus_write_r, write_s;
   logic [ADDR_W-1:0] bus_address_r, addr_s;
   logic [7:0]        bus_wdata_r, wdata_s;
   logic              cmd_ready_r, busy_r, done_r;
   logic              push_s, pop_s, load_rd_s, load_wr_s, drop_s, beat_acc_s;
   logic              cmd_fill_s;
   logic [7:0]        cmd_pattern_s, fifo_rdata;
   logic [CNT_W-1:0]  fifo_count;

`ifdef IP_BUS_DMA_FILL_EN
   assign cmd_fill_s    = cmd_fill;
   assign cmd_pattern_s = cmd_pattern;
`else
   assign cmd_fill_s    = 1'b0;
   assign cmd_pattern_s = 8'h00;
`endif

   function automatic logic [CNT_W-1:0] chunk_of(input logic [ADDR_W-1:0] n);
      if (n >= ADDR_W'(BUF_DEPTH)) begin
         return CNT_W'(BUF_DEPTH);
      end else begin
         return n[CNT_W-1:0];
      end
   endfunction

   assign beat_acc_s = bus_valid_r && bus_ready;

   ip_bus_dma_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push_s),
      .wdata   (bus_rdata),
      .pop     (pop_s),
      .rdata   (fifo_rdata),
      .count   (fifo_count)
   );

   // Next-state, counters and next bus beat; a beat is loaded into the output registers
   // either on entry to a phase or when the current beat is accepted
   always_comb begin
      state_s   = state_r;
      src_s     = src_r;
      dst_s     = dst_r;
      rem_s     = rem_r;
      chunk_s   = chunk_r;
      rd_cnt_s  = rd_cnt_r;
      rx_cnt_s  = rx_cnt_r;
      wr_cnt_s  = wr_cnt_r;
      fill_s    = fill_r;
      pattern_s = pattern_r;
      valid_s   = bus_valid_r;
      write_s   = bus_write_r;
      addr_s    = bus_address_r;
      wdata_s   = bus_wdata_r;
      push_s    = 1'b0;
      pop_s     = 1'b0;
      load_rd_s = 1'b0;
      load_wr_s = 1'b0;
      drop_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (cmd_valid && cmd_ready_r) begin
               src_s     = cmd_src;
               dst_s     = cmd_dst;
               rem_s     = cmd_len;
               fill_s    = cmd_fill_s;
               pattern_s = cmd_pattern_s;
               chunk_s   = chunk_of(cmd_len);
               rd_cnt_s  = '0;
               rx_cnt_s  = '0;
               wr_cnt_s  = '0;
               if (cmd_len == '0) begin
                  state_s = DONE;
               end else if (cmd_fill_s) begin
                  state_s   = WRITE;
                  load_wr_s = 1'b1;
               end else begin
                  state_s   = READ;
                  load_rd_s = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         READ: begin
            push_s   = bus_rdata_en;
            rx_cnt_s = rx_cnt_r + CNT_W'(bus_rdata_en);
            if (beat_acc_s && (rd_cnt_r == chunk_r)) begin
               state_s = DRAIN;
               drop_s  = 1'b1;
            end else begin
               load_rd_s = beat_acc_s;
            end
         end
         DRAIN: begin
            push_s   = bus_rdata_en;
            rx_cnt_s = rx_cnt_r + CNT_W'(bus_rdata_en);
            if (rx_cnt_s == chunk_r) begin
               state_s   = WRITE;
               wr_cnt_s  = '0;
               // Preload only when the head byte is already buffered
               load_wr_s = (fifo_count != '0);
            end else begin
               state_s = DRAIN;
            end
         end
         WRITE: begin
            if (beat_acc_s) begin
               rem_s = rem_r - ADDR_W'(1);
            end else begin
               rem_s = rem_r;
            end
            if ((beat_acc_s || !bus_valid_r) && (wr_cnt_r != chunk_r)) begin
               load_wr_s = 1'b1;
            end else if (beat_acc_s) begin
               chunk_s  = chunk_of(rem_s);
               rd_cnt_s = '0;
               rx_cnt_s = '0;
               wr_cnt_s = '0;
               if (rem_s == '0) begin
                  state_s = DONE;
                  drop_s  = 1'b1;
               end else if (fill_r) begin
                  load_wr_s = 1'b1;
               end else begin
                  state_s   = READ;
                  load_rd_s = 1'b1;
               end
            end else begin
               state_s = WRITE;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      if (load_rd_s) begin
         valid_s  = 1'b1;
         write_s  = 1'b0;
         addr_s   = src_s;
         src_s    = src_s + ADDR_W'(1);
         rd_cnt_s = rd_cnt_s + CNT_W'(1);
      end else if (load_wr_s) begin
         valid_s  = 1'b1;
         write_s  = 1'b1;
         addr_s   = dst_s;
         dst_s    = dst_s + ADDR_W'(1);
         wr_cnt_s = wr_cnt_s + CNT_W'(1);
         pop_s    = !fill_s;
         wdata_s  = fill_s ? pattern_s : fifo_rdata;
      end else if (drop_s) begin
         valid_s = 1'b0;
         write_s = 1'b0;
      end else begin
         valid_s = bus_valid_r;
      end
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r       <= IDLE;
         src_r         <= '0;
         dst_r         <= '0;
         rem_r         <= '0;
         chunk_r       <= '0;
         rd_cnt_r      <= '0;
         rx_cnt_r      <= '0;
         wr_cnt_r      <= '0;
         fill_r        <= 1'b0;
         pattern_r     <= 8'h00;
         bus_valid_r   <= 1'b0;
         bus_write_r   <= 1'b0;
         bus_address_r <= '0;
         bus_wdata_r   <= 8'h00;
         cmd_ready_r   <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
      end else begin
         state_r       <= state_s;
         src_r         <= src_s;
         dst_r         <= dst_s;
         rem_r         <= rem_s;
         chunk_r       <= chunk_s;
         rd_cnt_r      <= rd_cnt_s;
         rx_cnt_r      <= rx_cnt_s;
         wr_cnt_r      <= wr_cnt_s;
         fill_r        <= fill_s;
         pattern_r     <= pattern_s;
         bus_valid_r   <= valid_s;
         bus_write_r   <= write_s;
         bus_address_r <= addr_s;
         bus_wdata_r   <= wdata_s;
         cmd_ready_r   <= (state_s == IDLE);
         busy_r        <= (state_s != IDLE);
         done_r        <= (state_s == DONE);
      end
   end

   assign cmd_ready   = cmd_ready_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign bus_valid   = bus_valid_r;
   assign bus_write   = bus_write_r;
   assign bus_address = bus_address_r;
   assign bus_wdata   = bus_wdata_r;

endmodule

// File: tb/tb_ip_bus_dma.sv
// Scoreboard bench for ip_bus_dma against a 16KB RAM responder model.
module tb_ip_bus_dma;

   typedef struct packed { logic wr; logic [13:0] addr; logic [7:0] data; } beat_t;
   typedef struct { int due; logic [7:0] data; } pend_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [13:0] cmd_src, cmd_dst, cmd_len;
`ifdef IP_BUS_DMA_FILL_EN
   logic        cmd_fill;
   logic [7:0]  cmd_pattern;
`endif
   logic        busy, done;
   logic [13:0] bus_address;
   logic        bus_valid, bus_ready, bus_write, bus_rdata_en;
   logic [7:0]  bus_wdata, bus_rdata;

   logic [7:0]  mem [16384];
   beat_t       exp_q[$];
   int          exp_done[$];
   pend_t       pend_q[$];
   int          log_q[$];
   int          total = 0, bad = 0;
   int          beat_cnt = 0, done_cnt = 0, rd_acc = 0, valid_cnt = 0, mcyc = 0;
   bit          rand_mode = 1'b0;

   always #5 clk = ~clk;

   ip_bus_dma dut (
      .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
`ifdef IP_BUS_DMA_FILL_EN
      .cmd_fill(cmd_fill), .cmd_pattern(cmd_pattern),
`endif
      .busy(busy), .done(done), .bus_address(bus_address), .bus_valid(bus_valid),
      .bus_ready(bus_ready), .bus_write(bus_write), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_rdata_en(bus_rdata_en)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: got event expected none", name);
   endtask

   function automatic logic [7:0] init_val(input logic [13:0] a);
      return 8'((int'(a) * 13) + 5);
   endfunction

   // Expected beat stream of one command: per chunk, reads then writes
   task automatic expect_cmd(input logic [13:0] src, input logic [13:0] dst, input int len,
                             input logic fill, input logic [7:0] pat);
      int off = 0;
      int n;
      int beats = 0;
      beat_t b;
      while (off < len) begin
         n = (len - off > 4) ? 4 : len - off;
         if (!fill) begin
            for (int i = 0; i < n; i++) begin
               b.wr = 1'b0; b.addr = 14'(int'(src) + off + i); b.data = 8'h00;
               exp_q.push_back(b);
               beats++;
            end
         end
         for (int i = 0; i < n; i++) begin
            b.wr = 1'b1; b.addr = 14'(int'(dst) + off + i);
            b.data = fill ? pat : mem[14'(int'(src) + off + i)];
            exp_q.push_back(b);
            beats++;
         end
         off += n;
      end
      exp_done.push_back(beats);
   endtask

   task automatic send_cmd(input logic [13:0] src, input logic [13:0] dst, input logic [13:0] len,
                           input logic fill, input logic [7:0] pat);
      int n = 0;
      cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_valid = 1'b1;
`ifdef IP_BUS_DMA_FILL_EN
      cmd_fill = fill; cmd_pattern = pat;
`else
      if (fill || (pat != 8'h00)) $display("fill command requested in copy-only build");
`endif
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("cmd_accept", cmd_ready, 1'b1);
      @(negedge clk);
      cmd_valid = 1'b0;
`ifdef IP_BUS_DMA_FILL_EN
      cmd_fill = 1'b0;
`endif
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", done, 1'b1);
      @(negedge clk);
   endtask

   task automatic run_cmd(input logic [13:0] src, input logic [13:0] dst, input logic [13:0] len,
                          input logic fill, input logic [7:0] pat, input int budget);
      expect_cmd(src, dst, int'(len), fill, pat);
      send_cmd(src, dst, len, fill, pat);
      wait_done(budget);
   endtask

   // RAM responder: drives ready/rdata after each rising edge, in-order returns
   initial begin
      int    rcyc = 0, last_due = 0, due;
      bit    stalled = 1'b0;
      beat_t st;
      pend_t p;
      bus_ready = 1'b0; bus_rdata_en = 1'b0; bus_rdata = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         rcyc++;
         if (reset_n && stalled) begin
            check("stall_valid", bus_valid, 1'b1);
            check("stall_addr", bus_address, st.addr);
            check("stall_write", bus_write, st.wr);
            check("stall_wdata", bus_wdata, st.data);
         end
         if (pend_q.size() != 0 && pend_q[0].due <= rcyc) begin
            bus_rdata_en = 1'b1;
            bus_rdata    = pend_q[0].data;
            void'(pend_q.pop_front());
         end else begin
            bus_rdata_en = 1'b0;
         end
         bus_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bus_valid && bus_ready) begin
            if (bus_write) begin
               mem[bus_address] = bus_wdata;
            end else begin
               due = rcyc + (rand_mode ? int'($urandom_range(1, 6)) : 3);
               if (due <= last_due) due = last_due + 1;
               last_due = due;
               p.due = due; p.data = mem[bus_address];
               pend_q.push_back(p);
            end
         end
         stalled = bus_valid && !bus_ready;
         st.wr = bus_write; st.addr = bus_address; st.data = bus_wdata;
      end
   end

   // Monitor: pops the scoreboard on every accepted beat and every done pulse
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         mcyc++;
         if (bus_valid) valid_cnt++;
         if (bus_valid && bus_ready) begin
            log_q.push_back(mcyc);
            if (!bus_write) rd_acc++;
            beat_cnt++;
            if (exp_q.size() == 0) begin
               fail_now("beat_unexpected");
            end else begin
               e = exp_q.pop_front();
               check("beat_write", bus_write, e.wr);
               check("beat_addr", bus_address, e.addr);
               if (e.wr) check("beat_wdata", bus_wdata, e.data);
            end
         end
         if (done) begin
            done_cnt++;
            if (exp_done.size() == 0) begin
               fail_now("done_unexpected");
            end else begin
               check("done_beats", beat_cnt, exp_done.pop_front());
            end
            beat_cnt = 0;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0, v0, r0, n;
      reset_n = 1'b0; cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_len = '0;
`ifdef IP_BUS_DMA_FILL_EN
      cmd_fill = 1'b0; cmd_pattern = 8'h00;
`endif
      for (int i = 0; i < 16384; i++) mem[i] = init_val(14'(i));
      mem[14'h0010] = 8'h11; mem[14'h0011] = 8'h22; mem[14'h0012] = 8'h33; mem[14'h0013] = 8'h44;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_bus_valid", bus_valid, 1'b0);
      check("rst_bus_write", bus_write, 1'b0);
      check("rst_bus_address", bus_address, 14'h0000);
      check("rst_bus_wdata", bus_wdata, 8'h00);
      reset_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", cmd_ready, 1'b1);

      // Basic 4-byte copy with cycle timing
      log_q.delete(); d0 = done_cnt;
      run_cmd(14'h0010, 14'h0100, 14'd4, 1'b0, 8'h00, 200);
      check("copy4_b0", mem[14'h0100], 8'h11);
      check("copy4_b1", mem[14'h0101], 8'h22);
      check("copy4_b2", mem[14'h0102], 8'h33);
      check("copy4_b3", mem[14'h0103], 8'h44);
      check("copy4_done_count", done_cnt - d0, 1);
      check("copy4_beats", log_q.size(), 8);
      if (log_q.size() == 8) begin
         check("copy4_read_span", log_q[3] - log_q[0], 3);
         check("copy4_write_start", log_q[4] - log_q[0], 7);
         check("copy4_write_span", log_q[7] - log_q[4], 3);
      end

      // Zero-length command
      v0 = valid_cnt; d0 = done_cnt;
      expect_cmd(14'h0000, 14'h0000, 0, 1'b0, 8'h00);
      send_cmd(14'h0040, 14'h0050, 14'd0, 1'b0, 8'h00);
      check("len0_done_next", done, 1'b1);
      @(negedge clk);
      check("len0_no_valid", valid_cnt - v0, 0);
      check("len0_done_count", done_cnt - d0, 1);
      check("len0_ready_back", cmd_ready, 1'b1);

      // Address wrap, two chunks
      run_cmd(14'h3FFE, 14'h1000, 14'd5, 1'b0, 8'h00, 300);
      for (int i = 0; i < 5; i++)
         check("wrap_data", mem[14'h1000 + 14'(i)], init_val(14'(16382 + i)));

      // Random stalls and latency
      rand_mode = 1'b1;
      run_cmd(14'h0200, 14'h0800, 14'd37, 1'b0, 8'h00, 3000);
      rand_mode = 1'b0;
      repeat (10) @(negedge clk);
      for (int i = 0; i < 37; i++)
         check("rand_data", mem[14'h0800 + 14'(i)], init_val(14'h0200 + 14'(i)));

      // Reset during DRAIN with two reads outstanding
      d0 = done_cnt; r0 = rd_acc; n = 0;
      expect_cmd(14'h0500, 14'h0600, 8, 1'b0, 8'h00);
      send_cmd(14'h0500, 14'h0600, 14'd8, 1'b0, 8'h00);
      #1;
      while (rd_acc - r0 < 4 && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("rst_mid_reads", rd_acc - r0, 4);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      exp_q.delete(); exp_done.delete(); beat_cnt = 0;
      @(negedge clk);
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_valid", bus_valid, 1'b0);
      check("rst_mid_ready", cmd_ready, 1'b0);
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      check("rst_mid_no_done", done_cnt - d0, 0);
      run_cmd(14'h0700, 14'h0780, 14'd2, 1'b0, 8'h00, 200);
      check("post_rst_b0", mem[14'h0780], init_val(14'h0700));
      check("post_rst_b1", mem[14'h0781], init_val(14'h0701));
      check("post_rst_done", done_cnt - d0, 1);

`ifdef IP_BUS_DMA_FILL_EN
      r0 = rd_acc;
      run_cmd(14'h0000, 14'h2000, 14'd6, 1'b1, 8'hA5, 300);
      for (int i = 0; i < 6; i++)
         check("fill_data", mem[14'h2000 + 14'(i)], 8'hA5);
      check("fill_no_reads", rd_acc - r0, 0);
`endif

      repeat (5) @(negedge clk);
      check("end_queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
